priority_encoder: RTL and testbench
===================================

Name: priority_encoder

Overview:
- Registered N-to-log2(N) priority encoder.
- Reports the index of the highest-numbered asserted bit of input vector d on output y, with a valid flag.
- Default configuration is 8 inputs to a 3-bit index.
- Sits in datapath control logic (arbitration, leading-one detect) as a small synchronous leaf block.

Parameters:
- WIDTH, 8, number of request inputs; must be a power of two, 2 to 256.
- IDX_W, $clog2(WIDTH), width of the encoded index; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- d  input  WIDTH  request vector; bit i asserted means input i is active.
- y  output  IDX_W  encoded index of the highest asserted bit of d, registered.
- valid  output  1  registered; 1 when at least one bit of d was asserted.

Behaviour:
- Reset: on a rising clk edge with rst=1, y <= 0 and valid <= 0. Reset has priority over all other updates. Reset has no asynchronous effect.
- Encoding: combinational core computes idx = the largest i such that d[i]=1. MSB has the highest priority. Lower set bits are ignored.
  - Examples: 8'b00000001 -> 0; 8'b00000100 -> 2; 8'b10000000 -> 7; 8'b10100110 -> 7; 8'b00010011 -> 4.
- Zero input: d=0 gives idx=0 and any_set=0. y=0 alone is ambiguous with d=8'b00000001; valid disambiguates.
- Latency: exactly 1 clk cycle. Outputs sampled at edge k reflect d present before edge k.
  - Every cycle with rst=0: y <= idx; valid <= |d.
  - No enable and no handshake. Outputs track d every cycle.
- Outputs are glitch-free registers. No combinational path from d to y or valid.
- X on d is not supported; d must be driven to known values after reset.
- Reset mid-operation: the next edge with rst=1 clears y and valid regardless of d. The first edge after rst deasserts loads the encoding of the current d.
- The d=0 path and the single-hot paths use the same logic; no special-casing beyond any_set.

Decomposition:
- Shared package priority_encoder_pkg holds:
  - the default constant PE_WIDTH = 8;
  - a function pe_idx_w(width) returning $clog2(width), used for IDX_W.
- One natural sub-module: priority_encoder_core.
  - Purely combinational, parameterised by WIDTH.
  - Inputs: d. Outputs: idx and any_set.
  - Implemented as a descending-priority loop or a tree of 2:1 stages.
- The top level priority_encoder instantiates the core and adds the output register stage with synchronous reset.

Test Plan:
- Reset: hold rst=1 for 2 cycles with d=8'hFF -> y=0, valid=0. Release rst -> one cycle later y=7, valid=1.
- Walking one: d = 8'b00000001, 00000010, 00000100, … 10000000, one per cycle -> y = 0,1,2,…,7 with valid=1, each appearing one cycle after its stimulus.
- Zero input: d=8'h00 -> y=0, valid=0. Then d=8'h01 -> y=0, valid=1; valid alone distinguishes the two cases.
- Priority: d=8'b10100110 -> y=7; d=8'b00010011 -> y=4; d=8'b01111111 -> y=6; d=8'hFF -> y=7; valid=1 for all.
- Mid-stream reset: d=8'b00100000 stable, assert rst for 1 cycle -> y=0, valid=0 that cycle. Deassert -> y=5, valid=1 next cycle.
- Random: 1000 random d values each cycle -> y and valid match a reference model (highest set bit; any bit set) delayed by one cycle. Repeat with WIDTH=16, where d=16'h8001 -> y=15.

Source files
------------

// File: rtl/priority_encoder_pkg.sv
// Shared constants and helpers for the registered priority encoder.
package priority_encoder_pkg;

    localparam int PE_WIDTH = 8;

    function automatic int pe_idx_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/priority_encoder_core.sv
// Combinational leading-one detect: index of the highest set bit of d.
module priority_encoder_core
    import priority_encoder_pkg::*;
#(
    parameter  int WIDTH = PE_WIDTH,
    localparam int IDX_W = pe_idx_w(WIDTH)
) (
    input  logic [WIDTH-1:0] d,
    output logic [IDX_W-1:0] idx,
    output logic             any_set
);

    // Ascending scan where later matches overwrite earlier ones, so the highest set bit wins.
    always_comb begin
        idx     = '0;
        any_set = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (d[i]) begin
                idx     = IDX_W'(i);
                any_set = 1'b1;
            end
        end
    end

endmodule

// File: rtl/priority_encoder.sv
// Registered priority encoder: one-cycle latency, synchronous active-high reset.
module priority_encoder
    import priority_encoder_pkg::*;
#(
    parameter  int WIDTH = PE_WIDTH,
    localparam int IDX_W = pe_idx_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [IDX_W-1:0] y,
    output logic             valid
);

    logic [IDX_W-1:0] idx;
    logic             any_set;

    priority_encoder_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .d       (d),
        .idx     (idx),
        .any_set (any_set)
    );

    // Output register; valid disambiguates y=0 between d=0 and only bit 0 set.
    always_ff @(posedge clk) begin
        if (rst) begin
            y     <= '0;
            valid <= 1'b0;
        end else begin
            y     <= idx;
            valid <= any_set;
        end
    end

endmodule

// File: tb/tb_priority_encoder.sv
// Directed and random checks of priority_encoder at WIDTH=8 and WIDTH=16.
module tb_priority_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  d8;
    logic [2:0]  y8;
    logic        valid8;
    logic [15:0] d16;
    logic [3:0]  y16;
    logic        valid16;

    int checkCount = 0;
    int failCount  = 0;

    always #5 clk = ~clk;

    priority_encoder #(
        .WIDTH (8)
    ) dut8 (
        .clk   (clk),
        .rst   (rst),
        .d     (d8),
        .y     (y8),
        .valid (valid8)
    );

    priority_encoder #(
        .WIDTH (16)
    ) dut16 (
        .clk   (clk),
        .rst   (rst),
        .d     (d16),
        .y     (y16),
        .valid (valid16)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Drive inputs away from the edge, take one rising edge, settle before sampling.
    task automatic applyStimulus(input logic r, input logic [7:0] a, input logic [15:0] b);
        rst = r;
        d8  = a;
        d16 = b;
        @(posedge clk);
        #1;
    endtask

    function automatic int refIdx(input logic [15:0] v, input int w);
        for (int i = w - 1; i >= 0; i--)
            if (v[i]) return i;
        return 0;
    endfunction

    task automatic check8(input string tag, input int expY, input logic expV);
        checkOutput({tag, ".y"},     32'(y8),     32'(expY));
        checkOutput({tag, ".valid"}, 32'(valid8), 32'(expV));
    endtask

    task automatic check16(input string tag, input int expY, input logic expV);
        checkOutput({tag, ".y16"},     32'(y16),     32'(expY));
        checkOutput({tag, ".valid16"}, 32'(valid16), 32'(expV));
    endtask

    logic [7:0]  prioVec [4] = '{8'b10100110, 8'b00010011, 8'b01111111, 8'hFF};
    int          prioExp [4] = '{7, 4, 6, 7};
    logic [15:0] wideVec [4] = '{16'h8001, 16'h0001, 16'h0100, 16'h0000};
    int          wideExp [4] = '{15, 0, 8, 0};
    logic        wideV   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        rst = 1'b1;
        d8  = 8'hFF;
        d16 = 16'hFFFF;
        #1;

        applyStimulus(1'b1, 8'hFF, 16'hFFFF);
        check8("reset0", 0, 1'b0);
        check16("reset0", 0, 1'b0);
        applyStimulus(1'b1, 8'hFF, 16'hFFFF);
        check8("reset1", 0, 1'b0);
        applyStimulus(1'b0, 8'hFF, 16'hFFFF);
        check8("release", 7, 1'b1);
        check16("release", 15, 1'b1);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 8'(1 << i), 16'h0000);
            check8($sformatf("walk%0d", i), i, 1'b1);
        end

        applyStimulus(1'b0, 8'h00, 16'h0000);
        check8("zero", 0, 1'b0);
        applyStimulus(1'b0, 8'h01, 16'h0000);
        check8("bit0", 0, 1'b1);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, prioVec[i], 16'h0000);
            check8($sformatf("prio%0d", i), prioExp[i], 1'b1);
        end

        applyStimulus(1'b0, 8'b00100000, 16'h0020);
        check8("preRst", 5, 1'b1);
        applyStimulus(1'b1, 8'b00100000, 16'h0020);
        check8("midRst", 0, 1'b0);
        check16("midRst", 0, 1'b0);
        applyStimulus(1'b0, 8'b00100000, 16'h0020);
        check8("postRst", 5, 1'b1);
        check16("postRst", 5, 1'b1);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 8'h00, wideVec[i]);
            check16($sformatf("wide%0d", i), wideExp[i], wideV[i]);
        end

        for (int i = 0; i < 1000; i++) begin
            logic [7:0]  r8;
            logic [15:0] r16;
            r8  = 8'($urandom);
            r16 = 16'($urandom);
            if (i % 4 == 0) r8 = r8 & 8'($urandom);
            if (i % 50 == 0) r8 = 8'h00;
            applyStimulus(1'b0, r8, r16);
            check8($sformatf("rand%0d", i), refIdx({8'h00, r8}, 8), |r8);
            check16($sformatf("rand%0d", i), refIdx(r16, 16), |r16);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
